fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_buf.sv | 52 +++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch FSM state encoding and PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: synchronous FIFO of {instr, pc} entries with push/pop/flush and registered head.
module fetch_buf #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  data_i,
    output logic [CW-1:0] count_o,
    output logic          valid_o,
    output logic [W-1:0]  head_o
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= inc(wr_q);
            if (pop_i) rd_q <= inc(rd_q);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
        end else if (push_i && !flush_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign count_o = cnt_q;
    assign valid_o = (cnt_q != '0);
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch feeding a DEPTH-entry buffer.
// Define FETCH_ALIGN_CHK_EN to add sticky align_fault and reject misaligned redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
`ifdef FETCH_ALIGN_CHK_EN
    output logic        align_fault,
`endif
    input  logic        redirect,
    input  logic [31:0] redirect_target
);
    localparam int            CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, addr_q, addr_d;
    logic [31:0]   target, pc_inc;
    logic [CW-1:0] count, count_nxt;
    logic          redir, push, pop;
    logic [63:0]   head;

`ifdef FETCH_ALIGN_CHK_EN
    logic align_fault_q;
    assign redir       = redirect && (redirect_target[1:0] == 2'b00);
    assign target      = redirect_target;
    assign align_fault = align_fault_q;
    always_ff @(posedge clk) begin
        align_fault_q <= reset ? 1'b0 : (align_fault_q || (redirect && |redirect_target[1:0]));
    end
`else
    assign redir  = redirect;
    assign target = {redirect_target[31:2], 2'b00};
`endif

    assign pop       = instr_valid && instr_ready;
    assign push      = (state_q == REQ) && imem_ack && !redir;
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign pc_inc    = fetch_pc_q + PC_INC;
    assign imem_req  = (state_q != IDLE);
    assign imem_addr = addr_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: begin
                if (redir) begin
                    state_d    = REQ;
                    fetch_pc_d = target;
                    addr_d     = target;
                end else if (count < FULL) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (redir) begin
                    fetch_pc_d = target;
                    addr_d     = imem_ack ? target : addr_q;
                    state_d    = imem_ack ? REQ : DROP;
                end else if (imem_ack) begin
                    fetch_pc_d = pc_inc;
                    addr_d     = (count_nxt < FULL) ? pc_inc : addr_q;
                    state_d    = (count_nxt < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                // the stale request stays on the bus until acked; its data is discarded
                fetch_pc_d = redir ? target : fetch_pc_q;
                if (imem_ack) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    fetch_buf #(.DEPTH(DEPTH), .W(64)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redir),
        .data_i  ({imem_rdata, imem_addr}),
        .count_o (count),
        .valid_o (instr_valid),
        .head_o  (head)
    );

    assign instr    = head[63:32];
    assign instr_pc = head[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tests for fetch_unit; memory returns addr ^ 32'hDEAD_BEEF.
module tb_fetch_unit;
    localparam logic [31:0] K = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack, instr_valid;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        auto_ack = 1'b0;
    logic        ack_force = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    logic        align_fault;
`endif
    int total = 0;
    int bad = 0;

    assign imem_ack   = imem_req && (auto_ack || ack_force);
    assign imem_rdata = imem_addr ^ K;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
`ifdef FETCH_ALIGN_CHK_EN
        .align_fault     (align_fault),
`endif
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h40;
        auto_ack = 1'b1;
        instr_ready = 1'b1;
        tick();
        tick();
        total++;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        total++;
        if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
        total++;
        if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 00000000", instr); end
        total++;
        if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 00000000", instr_pc); end
`ifdef FETCH_ALIGN_CHK_EN
        total++;
        if (align_fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %0b want 0", align_fault); end
`endif
        redirect = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_stream();
        auto_ack = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL stream_first_req: got req=%0b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
        end
        tick();
        total++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, K}) begin
            bad++; $display("FAIL stream_first_instr: got v=%0b pc=%h i=%h want v=1 pc=00000000 i=%h", instr_valid, instr_pc, instr, K);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 32'(4 * k), 32'(4 * k) ^ K}) begin
                bad++; $display("FAIL stream_seq%0d: got v=%0b pc=%h i=%h want pc=%h", k, instr_valid, instr_pc, instr, 32'(4 * k));
            end
        end
    endtask

    task automatic test_full();
        auto_ack = 1'b1;
        instr_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        total++;
        if ({imem_req, instr_valid, instr_pc} !== {1'b0, 1'b1, 32'h0}) begin
            bad++; $display("FAIL full_idle: got req=%0b v=%0b pc=%h want req=0 v=1 pc=00000000", imem_req, instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        total++;
        if ({imem_req, instr_pc} !== {1'b0, 32'h4}) begin
            bad++; $display("FAIL full_pop1: got req=%0b pc=%h want req=0 pc=00000004", imem_req, instr_pc);
        end
        tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            bad++; $display("FAIL full_refill: got req=%0b addr=%h want req=1 addr=00000008", imem_req, imem_addr);
        end
        tick();
        tick();
        total++;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL full_one_req: got req=%0b want 0", imem_req); end
        instr_ready = 1'b1;
        tick();
        total++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h8}) begin
            bad++; $display("FAIL full_pop2: got v=%0b pc=%h want v=1 pc=00000008", instr_valid, instr_pc);
        end
        tick();
        total++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'hC}) begin
            bad++; $display("FAIL full_drain: got v=%0b req=%0b addr=%h want v=0 req=1 addr=0000000c", instr_valid, imem_req, imem_addr);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_drop();
        auto_ack = 1'b0;
        ack_force = 1'b0;
        instr_ready = 1'b1;
        do_reset();
        tick();
        tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL drop_hold: got req=%0b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
        end
        ack_force = 1'b1;
        tick();
        tick();
        ack_force = 1'b0;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            bad++; $display("FAIL drop_pending: got req=%0b addr=%h want req=1 addr=00000008", imem_req, imem_addr);
        end
        redirect = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect = 1'b0;
        total++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h8}) begin
            bad++; $display("FAIL drop_stale: got v=%0b req=%0b addr=%h want v=0 req=1 addr=00000008", instr_valid, imem_req, imem_addr);
        end
        tick();
        tick();
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        total++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            bad++; $display("FAIL drop_retarget: got v=%0b req=%0b addr=%h want v=0 req=1 addr=00000100", instr_valid, imem_req, imem_addr);
        end
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        total++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, 32'h100 ^ K}) begin
            bad++; $display("FAIL drop_first: got v=%0b pc=%h i=%h want v=1 pc=00000100", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_redirect_ack_pop();
        auto_ack = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        repeat (5) tick();
        total++;
        if ({imem_addr, instr_valid, instr_pc} !== {32'h10, 1'b1, 32'hC}) begin
            bad++; $display("FAIL rap_setup: got addr=%h v=%0b pc=%h want addr=00000010 v=1 pc=0000000c", imem_addr, instr_valid, instr_pc);
        end
        redirect = 1'b1;
        redirect_target = 32'h200;
        tick();
        redirect = 1'b0;
        total++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
            bad++; $display("FAIL rap_flush: got v=%0b req=%0b addr=%h want v=0 req=1 addr=00000200", instr_valid, imem_req, imem_addr);
        end
        tick();
        total++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h200}) begin
            bad++; $display("FAIL rap_first: got v=%0b pc=%h want v=1 pc=00000200", instr_valid, instr_pc);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        total++;
        if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr); end
        tick();
        total++;
        if ({imem_addr, instr_pc} !== {32'h0, 32'hFFFF_FFFC}) begin
            bad++; $display("FAIL wrap_addr1: got addr=%h pc=%h want addr=00000000 pc=fffffffc", imem_addr, instr_pc);
        end
        tick();
        total++;
        if ({imem_addr, instr_pc, instr} !== {32'h4, 32'h0, K}) begin
            bad++; $display("FAIL wrap_pc: got addr=%h pc=%h i=%h want addr=00000004 pc=00000000", imem_addr, instr_pc, instr);
        end
    endtask

    task automatic test_align();
        auto_ack = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        repeat (3) tick();
        redirect = 1'b1;
        redirect_target = 32'h102;
        tick();
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        total++;
        if ({align_fault, imem_addr, instr_valid, instr_pc} !== {1'b1, 32'hC, 1'b1, 32'h8}) begin
            bad++; $display("FAIL align_ignore: got f=%0b addr=%h v=%0b pc=%h want f=1 addr=0000000c v=1 pc=00000008", align_fault, imem_addr, instr_valid, instr_pc);
        end
        tick();
        tick();
        total++;
        if ({align_fault, instr_pc} !== {1'b1, 32'h10}) begin
            bad++; $display("FAIL align_sticky: got f=%0b pc=%h want f=1 pc=00000010", align_fault, instr_pc);
        end
        do_reset();
        total++;
        if (align_fault !== 1'b0) begin bad++; $display("FAIL align_clear: got %0b want 0", align_fault); end
`else
        total++;
        if ({instr_valid, imem_addr} !== {1'b0, 32'h100}) begin
            bad++; $display("FAIL align_force: got v=%0b addr=%h want v=0 addr=00000100", instr_valid, imem_addr);
        end
        tick();
        total++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h100}) begin
            bad++; $display("FAIL align_first: got v=%0b pc=%h want v=1 pc=00000100", instr_valid, instr_pc);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_drop();
        test_redirect_ack_pop();
        test_wrap();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
